// File: rtl/lcd_pkg.sv
// Shared constants and types for the HD44780 refresh sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] LINE1    = 8'h80;
    localparam logic [7:0] LINE2    = 8'hC0;

    typedef enum logic [2:0] {PWR, INIT, ADDR, FETCH, WRITE} top_state_t;

    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_EHI, PH_HOLD} strobe_phase_t;

    // One panel write: register select, bus byte and E-low hold length.
    typedef struct packed {
        logic        rs;
        logic [7:0]  data;
        logic [15:0] hold;
    } wr_req_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    return FUNC_SET;
            2'd1:    return DISP_ON;
            2'd2:    return ENTRY;
            default: return CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// Drives one panel write as SETUP / EHI / HOLD with RS and data held for the whole write.
// Latency: 1 + E_HIGH + hold cycles from the cycle after start; done is high in the last HOLD cycle.
// Backpressure: start is accepted only when idle or in the done cycle (back-to-back writes).
module lcd_write_strobe
    import lcd_pkg::*;
#(
    parameter int unsigned E_HIGH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  wr_req_t    req,
    output logic       e,
    output logic       rs,
    output logic [7:0] data,
    output logic       done
);

    localparam logic [15:0] EHI_LAST = 16'(E_HIGH - 1);

    strobe_phase_t phase, phase_nxt;
    logic [15:0]   cnt, cnt_nxt;
    wr_req_t       req_q;
    logic          accept;

    assign accept = start && ((phase == PH_IDLE) || done);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= PH_IDLE;
            cnt   <= '0;
            req_q <= '0;
        end else begin
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
            if (accept) req_q <= req;
        end
    end

    always_comb begin
        phase_nxt = phase;
        cnt_nxt   = cnt;
        case (phase)
            PH_IDLE:  if (accept) phase_nxt = PH_SETUP;
            PH_SETUP: begin
                phase_nxt = PH_EHI;
                cnt_nxt   = EHI_LAST;
            end
            PH_EHI: begin
                if (cnt == 16'd0) begin
                    phase_nxt = PH_HOLD;
                    cnt_nxt   = req_q.hold - 16'd1;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            PH_HOLD: begin
                if (cnt == 16'd0) phase_nxt = accept ? PH_SETUP : PH_IDLE;
                else              cnt_nxt   = cnt - 16'd1;
            end
            default: phase_nxt = PH_IDLE;
        endcase
    end

    always_comb begin
        e    = (phase == PH_EHI);
        rs   = req_q.rs;
        data = req_q.data;
        done = (phase == PH_HOLD) && (cnt == 16'd0);
    end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// 16x2 HD44780 sequencer: power-up wait, init commands, then endless 32-slot line refresh.
// Latency: first command after PWR_WAIT cycles; frame = 2*(1+E_HIGH+CMD_WAIT) + 32*(3+E_HIGH+CMD_WAIT).
// Backpressure: none; panel is write-only and paced purely by the fixed hold timers.
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned PWR_WAIT = 20000,
    parameter int unsigned E_HIGH   = 4,
    parameter int unsigned CMD_WAIT = 50,
    parameter int unsigned CLR_WAIT = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    output logic [4:0] index,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       frame_done
);

    localparam logic [15:0] PWR_LAST = (PWR_WAIT > 0) ? 16'(PWR_WAIT - 1) : 16'd0;
    localparam logic [15:0] CMD_HOLD = 16'(CMD_WAIT);
    localparam logic [15:0] CLR_HOLD = 16'(CLR_WAIT);

    top_state_t  state, state_nxt;
    logic [15:0] pwr_cnt, pwr_cnt_nxt;
    logic [1:0]  step, step_nxt;
    logic        fetch_cnt, fetch_cnt_nxt;
    logic [4:0]  idx, idx_nxt;

    logic        start;
    wr_req_t     req;
    logic        wr_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PWR;
            pwr_cnt   <= '0;
            step      <= '0;
            fetch_cnt <= 1'b0;
            idx       <= '0;
        end else begin
            state     <= state_nxt;
            pwr_cnt   <= pwr_cnt_nxt;
            step      <= step_nxt;
            fetch_cnt <= fetch_cnt_nxt;
            idx       <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pwr_cnt_nxt   = pwr_cnt;
        step_nxt      = step;
        fetch_cnt_nxt = fetch_cnt;
        idx_nxt       = idx;
        case (state)
            PWR: begin
                if (pwr_cnt == PWR_LAST) begin
                    state_nxt = INIT;
                    step_nxt  = 2'd0;
                end else begin
                    pwr_cnt_nxt = pwr_cnt + 16'd1;
                end
            end
            INIT: begin
                if (wr_done) begin
                    if (step == 2'd3) state_nxt = ADDR;
                    else              step_nxt  = step + 2'd1;
                end
            end
            ADDR: begin
                if (wr_done) begin
                    state_nxt     = FETCH;
                    fetch_cnt_nxt = 1'b0;
                end
            end
            FETCH: begin
                // Two cycles so the registered display list has answered for the new index.
                if (fetch_cnt) state_nxt     = WRITE;
                else           fetch_cnt_nxt = 1'b1;
            end
            WRITE: begin
                if (wr_done) begin
                    if (idx == 5'd15) begin
                        state_nxt = ADDR;
                        idx_nxt   = 5'd16;
                    end else if (idx == 5'd31) begin
                        state_nxt = ADDR;
                        idx_nxt   = 5'd0;
                    end else begin
                        state_nxt     = FETCH;
                        fetch_cnt_nxt = 1'b0;
                        idx_nxt       = idx + 5'd1;
                    end
                end
            end
            default: state_nxt = PWR;
        endcase
    end

    // Next write is requested in the done cycle of the previous one so SETUP follows with no gap.
    always_comb begin
        start      = 1'b0;
        req        = '{rs: 1'b0, data: 8'h00, hold: CMD_HOLD};
        frame_done = 1'b0;
        case (state)
            PWR: begin
                if (pwr_cnt == PWR_LAST) begin
                    start    = 1'b1;
                    req.data = FUNC_SET;
                end
            end
            INIT: begin
                if (wr_done) begin
                    start = 1'b1;
                    if (step == 2'd3) begin
                        req.data = LINE1;
                    end else begin
                        req.data = init_cmd(step + 2'd1);
                        if (step == 2'd2) req.hold = CLR_HOLD;
                    end
                end
            end
            FETCH: begin
                if (fetch_cnt) begin
                    start    = 1'b1;
                    req.rs   = 1'b1;
                    req.data = char_in;
                end
            end
            WRITE: begin
                if (wr_done && idx == 5'd15) begin
                    start    = 1'b1;
                    req.data = LINE2;
                end else if (wr_done && idx == 5'd31) begin
                    start      = 1'b1;
                    req.data   = LINE1;
                    frame_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    lcd_write_strobe #(
        .E_HIGH (E_HIGH)
    ) u_strobe (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .req   (req),
        .e     (lcd_e),
        .rs    (lcd_rs),
        .data  (lcd_data),
        .done  (wr_done)
    );

    assign index  = idx;
    assign lcd_rw = 1'b0;

endmodule
